// File: rtl/dio_pkg.sv
// Shared encodings for the digital I/O channel controller: pin modes,
// config opcodes and sequencer states.
package dio_pkg;
  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    MODE_HIZ  = 2'b00,
    MODE_LOW  = 2'b01,
    MODE_HIGH = 2'b10,
    MODE_PAT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_SET_MODE = 2'b00,
    OP_BCAST    = 2'b01,
    OP_PAT_WR   = 2'b10,
    OP_SEQ_CTRL = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;
endpackage

// File: rtl/dio_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
module dio_sync2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dio_chan_ctrl.sv
// Digital I/O channel controller: per-channel static/pattern drive modes,
// a pattern memory played out by a small sequencer, and input synchronisation.
module dio_chan_ctrl
  import dio_pkg::*;
#(
  parameter int NUM_CH    = 32,
  parameter int PAT_DEPTH = 16,
  parameter int STEP_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_op,
  input  logic [7:0]        cfg_addr,
  input  logic [NUM_CH-1:0] cfg_data,
  input  logic [NUM_CH-1:0] dio_in,
  output logic [NUM_CH-1:0] dio_out,
  output logic [NUM_CH-1:0] dio_oe,
  output logic [NUM_CH-1:0] dio_sync,
  output logic              seq_busy,
  output logic              seq_done
);
  localparam int IW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0][1:0] mode;
  logic [NUM_CH-1:0]      pat [PAT_DEPTH];
  seq_state_e             state;
  logic [IW-1:0]          idx, end_idx;
  logic                   loop;
  logic [DIV_W-1:0]       div;
  logic [NUM_CH-1:0]      last_word, word;
  logic [NUM_CH-1:0]      out_nxt, oe_nxt;
  logic                   accept;

  assign seq_busy  = (state == ST_RUN);
  assign cfg_ready = !(seq_busy && cfg_op == OP_PAT_WR);
  assign accept    = cfg_valid && cfg_ready;
  // While idle the outputs keep showing the last word played, not live memory.
  assign word      = seq_busy ? pat[idx] : last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= '0;
    end else if (accept) begin
      case (op_e'(cfg_op))
        OP_SET_MODE: if (int'(cfg_addr) < NUM_CH) mode[cfg_addr[CW-1:0]] <= cfg_data[1:0];
        OP_BCAST:    for (int c = 0; c < NUM_CH; c++) mode[c] <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAT_DEPTH; i++) pat[i] <= '0;
    end else if (accept && cfg_op == OP_PAT_WR && int'(cfg_addr) < PAT_DEPTH) begin
      pat[cfg_addr[IW-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      end_idx   <= '0;
      loop      <= 1'b0;
      div       <= '0;
      last_word <= '0;
      seq_done  <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (seq_busy) last_word <= pat[idx];
      if (accept && cfg_op == OP_SEQ_CTRL) begin
        end_idx <= (int'(cfg_addr) >= PAT_DEPTH) ? IW'(PAT_DEPTH - 1) : cfg_addr[IW-1:0];
        loop    <= cfg_data[1];
        if (cfg_data[0]) begin
          state <= ST_RUN;
          idx   <= '0;
          div   <= '0;
        end else begin
          state <= ST_IDLE;
        end
      end else if (seq_busy) begin
        if (div == DIV_W'(STEP_DIV - 1)) begin
          div <= '0;
          if (idx == end_idx) begin
            if (loop) begin
              idx <= '0;
            end else begin
              state    <= ST_IDLE;
              seq_done <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_nxt = '0;
    oe_nxt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      oe_nxt[c]  = (mode[c] != MODE_HIZ);
      out_nxt[c] = (mode[c] == MODE_HIGH) || (mode[c] == MODE_PAT && word[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dio_out <= '0;
      dio_oe  <= '0;
    end else begin
      dio_out <= out_nxt;
      dio_oe  <= oe_nxt;
    end
  end

  dio_sync2 #(.W(NUM_CH)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dio_in),
    .q    (dio_sync)
  );
endmodule

// File: tb/tb_dio_chan_ctrl.sv
// Self-checking bench for dio_chan_ctrl: expected sequencer output per cycle
// is queued from a pattern model when a sequence is started, then popped and compared.
module tb_dio_chan_ctrl;
  import dio_pkg::*;

  localparam int NCH = 32;
  localparam int PD  = 16;
  localparam int SD  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_op = 2'b00;
  logic [7:0]     cfg_addr = 8'd0;
  logic [NCH-1:0] cfg_data = '0;
  logic [NCH-1:0] dio_in = '0;
  logic [NCH-1:0] dio_out, dio_oe, dio_sync;
  logic           seq_busy, seq_done;

  int n_vec = 0;
  int n_err = 0;

  logic [NCH-1:0] pat_m [PD];

  typedef struct {
    logic [NCH-1:0] out;
    logic           busy;
    logic           done;
  } exp_t;
  exp_t sb[$];

  dio_chan_ctrl #(.NUM_CH(NCH), .PAT_DEPTH(PD), .STEP_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dio_in(dio_in), .dio_out(dio_out), .dio_oe(dio_oe), .dio_sync(dio_sync),
    .seq_busy(seq_busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] addr, input logic [NCH-1:0] data);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_addr  = addr;
    cfg_data  = data;
    step();
    cfg_valid = 1'b0;
    if (op == OP_PAT_WR && int'(addr) < PD) pat_m[addr] = data;
  endtask

  // Called right after a start command is accepted; all channels in PAT mode.
  task automatic play(input string tag, input int n, input int endi, input bit lp);
    exp_t e;
    int   idx;
    for (int k = 1; k <= n; k++) begin
      idx = (k - 1) / SD;
      if (lp) idx = idx % (endi + 1);
      else if (idx > endi) idx = endi;
      e.out  = pat_m[idx];
      e.busy = lp ? 1'b1 : (k < (endi + 1) * SD);
      e.done = !lp && (k == (endi + 1) * SD);
      sb.push_back(e);
    end
    for (int k = 1; k <= n; k++) begin
      step();
      e = sb.pop_front();
      chk({tag, "_out"},  dio_out,  e.out);
      chk({tag, "_busy"}, seq_busy, e.busy);
      chk({tag, "_done"}, seq_done, e.done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < PD; i++) pat_m[i] = '0;
    cfg_op = OP_PAT_WR;
    repeat (3) step();
    chk("rst_oe", dio_oe, 0);
    chk("rst_out", dio_out, 0);
    chk("rst_sync", dio_sync, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", cfg_ready, 1);

    cmd(OP_BCAST, 8'd0, NCH'(2));
    chk("lat_oe", dio_oe, 0);
    step();
    chk("bc_oe", dio_oe, 32'hFFFF_FFFF);
    chk("bc_out", dio_out, 32'hFFFF_FFFF);

    cmd(OP_SET_MODE, 8'd5, NCH'(0));
    step();
    chk("set5_oe", dio_oe, 32'hFFFF_FFDF);
    chk("set5_out", dio_out, 32'hFFFF_FFDF);

    cmd(OP_SET_MODE, 8'd200, NCH'(0));
    step();
    chk("set200_oe", dio_oe, 32'hFFFF_FFDF);
    chk("set200_out", dio_out, 32'hFFFF_FFDF);

    cmd(OP_PAT_WR, 8'd0, NCH'(1));
    cmd(OP_PAT_WR, 8'd1, NCH'(2));
    cmd(OP_PAT_WR, 8'd2, NCH'(4));
    cmd(OP_PAT_WR, 8'd3, NCH'(8));
    cmd(OP_BCAST, 8'd0, NCH'(3));
    step();
    chk("pat_idle_oe", dio_oe, 32'hFFFF_FFFF);
    chk("pat_idle_out", dio_out, 0);

    cmd(OP_SEQ_CTRL, 8'd3, NCH'(1));
    play("seq", 12, 3, 1'b0);

    cmd(OP_SEQ_CTRL, 8'd1, NCH'(3));
    play("loop", 12, 1, 1'b1);
    cmd(OP_SEQ_CTRL, 8'd1, NCH'(0));
    chk("stop_busy", seq_busy, 0);
    chk("stop_done", seq_done, 0);
    step();
    chk("stop_done2", seq_done, 0);

    cmd(OP_SEQ_CTRL, 8'd1, NCH'(1));
    cfg_valid = 1'b1;
    cfg_op    = OP_PAT_WR;
    cfg_addr  = 8'd3;
    cfg_data  = NCH'(32'h55);
    #1;
    chk("stall_ready", cfg_ready, 0);
    w = 0;
    while (!cfg_ready && w < 20) begin
      step();
      w++;
    end
    chk("stall_cycles", w, 4);
    step();
    cfg_valid = 1'b0;
    pat_m[3] = NCH'(32'h55);
    cmd(OP_SEQ_CTRL, 8'd3, NCH'(1));
    play("wr", 9, 3, 1'b0);

    dio_in[7] = 1'b1;
    step();
    chk("sync_r1", dio_sync[7], 0);
    step();
    chk("sync_r2", dio_sync[7], 1);
    dio_in[7] = 1'b0;
    step();
    chk("sync_f1", dio_sync[7], 1);
    step();
    chk("sync_f2", dio_sync[7], 0);

    dio_in = '1;
    cmd(OP_SEQ_CTRL, 8'd1, NCH'(3));
    step();
    step();
    chk("pre_rst_sync", dio_sync, 32'hFFFF_FFFF);
    chk("pre_rst_busy", seq_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_oe", dio_oe, 0);
    chk("mrst_out", dio_out, 0);
    chk("mrst_sync", dio_sync, 0);
    chk("mrst_busy", seq_busy, 0);
    chk("mrst_done", seq_done, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_done", seq_done, 0);
      chk("post_rst_busy", seq_busy, 0);
    end
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_oe", dio_oe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dio_chan_ctrl.md
DIO_CHAN_CTRL -- requirements
Module: dio_chan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 32, number of digital I/O channels (legal range 8..64).
REQ-002 SHALL have parameter PAT_DEPTH, default 16, number of pattern words (power of two, 2..256).
REQ-003 SHALL have parameter STEP_DIV, default 1, clocks each pattern word is held (1..65535).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1, configuration command valid.
REQ-007 SHALL have port cfg_ready, output, 1, command accepted when cfg_valid and cfg_ready are both 1.
REQ-008 SHALL have port cfg_op, input, 2, opcode: 00 SET_MODE, 01 BCAST, 10 PAT_WR, 11 SEQ_CTRL.
REQ-009 SHALL have port cfg_addr, input, 8, channel index, pattern index or sequence end index.
REQ-010 SHALL have port cfg_data, input, NUM_CH, command payload.
REQ-011 SHALL have port dio_in, input, NUM_CH, asynchronous pad input levels.
REQ-012 SHALL have port dio_out, output, NUM_CH, per-channel drive level.
REQ-013 SHALL have port dio_oe, output, NUM_CH, per-channel output enable (1 = drive); pad tri-state lives outside this block.
REQ-014 SHALL have port dio_sync, output, NUM_CH, dio_in after two-flop synchronisation.
REQ-015 SHALL have port seq_busy, output, 1, high while sequencer is in RUN.
REQ-016 SHALL have port seq_done, output, 1, one-cycle pulse on non-loop sequence completion.

Function
REQ-017 SHALL hold a 2-bit mode per channel: HIZ 00 (oe=0, out=0), LOW 01 (oe=1, out=0), HIGH 10 (oe=1, out=1), PAT 11 (oe=1, out = current pattern word bit of that channel).
REQ-018 SET_MODE SHALL write cfg_data[1:0] to channel cfg_addr; cfg_addr >= NUM_CH accepted with no effect.
REQ-019 BCAST SHALL write cfg_data[1:0] to all channels in one cycle.
REQ-020 PAT_WR SHALL write cfg_data to pattern entry cfg_addr; cfg_addr >= PAT_DEPTH accepted with no effect.
REQ-021 SEQ_CTRL SHALL use cfg_data[0] run (1 start, 0 stop), cfg_data[1] loop, cfg_addr end index (clamped to PAT_DEPTH-1).
REQ-022 cfg_ready SHALL be 1 except while seq_busy=1 and cfg_op=PAT_WR (write stalls until IDLE); cfg_ready SHALL NOT depend on cfg_valid.
REQ-023 dio_out/dio_oe SHALL be registered: command accepted at edge N shows at outputs after edge N+1.
REQ-024 Sequencer FSM states IDLE, RUN: IDLE->RUN on start; index=0, divider=0 on entry.
REQ-025 In RUN, index SHALL advance after STEP_DIV clocks; at end index: loop=1 wraps to 0, loop=0 goes IDLE with seq_done pulsed one cycle.
REQ-026 Start while RUN SHALL restart at index 0; stop SHALL go IDLE next cycle without seq_done.
REQ-027 In IDLE, current pattern word SHALL hold its last value (entry 0 after reset).
REQ-028 Mode changes during RUN SHALL take effect without disturbing sequencer index or divider.
REQ-029 dio_sync SHALL lag dio_in by exactly two clk edges.

Reset
REQ-030 rst_n low SHALL immediately force: all modes HIZ, dio_oe=0, dio_out=0, dio_sync=0, pattern memory 0, FSM IDLE, index 0, end 0, loop 0, seq_done=0; cfg_ready=1 after release.
REQ-031 Reset mid-sequence SHALL abort without seq_done.

Structure
REQ-032 Package dio_pkg SHALL hold mode encodings, opcode encodings and FSM state type.
REQ-033 Synchroniser SHALL be sub-module dio_sync2 (NUM_CH-wide, two flops, async reset).

Verification
REQ-034 Reset, BCAST data=2 -> next cycle dio_oe=all 1, dio_out=all 1; SET_MODE addr 5 data 0 -> bit5 oe=0.
REQ-035 PAT_WR 0..3 with 0x1,0x2,0x4,0x8, BCAST 3, SEQ_CTRL run=1 loop=0 end=3, STEP_DIV=2 -> dio_out 1,2,4,8 each 2 cycles, seq_done once, output holds 0x8.
REQ-036 Loop=1 end=1 -> dio_out alternates entries 0,1 indefinitely, seq_done never; stop -> IDLE next cycle.
REQ-037 PAT_WR during RUN -> cfg_ready=0 until IDLE, then write lands; SET_MODE addr 200 -> no change.
REQ-038 Toggle dio_in bit 7 -> dio_sync bit 7 follows two edges later; assert rst_n mid-RUN -> all outputs reset, no seq_done.
